ysyx_ifu_l1i: RTL and testbench

Parametrised instruction fetch unit with a set-associative, multi-word-line L1 instruction cache and burst refill. It sits between PC generation (upstream valid/ready) and decode (downstream valid/ready), issuing line-sized bursts to the memory bus on a miss. It adds a fence.i flush and hit/miss performance pulses, and supports back-pressure on both handshakes.

---
 rtl/ysyx_ifu_l1i_pkg.sv | 17 +
 rtl/ysyx_ifu_l1i_if.sv | 40 ++++
 rtl/ysyx_ifu_l1i_array.sv | 60 ++++++
 rtl/ysyx_ifu_l1i.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_ifu_l1i.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_ifu_l1i_pkg.sv
// ysyx IFU L1I shared definitions.
// FSM states and address-field width helpers.
package ysyx_ifu_l1i_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_AR,
    S_R,
    S_HOLD
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_ifu_l1i_if.sv
// ysyx IFU L1I handshake and burst bus bundle.
// master = fetch unit side, slave = pcgen/decode/memory side.
interface ysyx_ifu_l1i_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              prev_valid;
  logic              ready_o;
  logic [ADDR_W-1:0] pc;
  logic              next_ready;
  logic              valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              fence_i;
  logic [ADDR_W-1:0] ifu_araddr_o;
  logic [7:0]        ifu_arlen_o;
  logic              ifu_arvalid_o;
  logic              ifu_arready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_rlast;
  logic              perf_hit_o;
  logic              perf_miss_o;

  modport master (
    input  prev_valid, pc, next_ready, fence_i,
    input  ifu_arready, ifu_rdata, ifu_rvalid, ifu_rlast,
    output ready_o, valid_o, inst_o, pc_o,
    output ifu_araddr_o, ifu_arlen_o, ifu_arvalid_o,
    output perf_hit_o, perf_miss_o
  );

  modport slave (
    output prev_valid, pc, next_ready, fence_i,
    output ifu_arready, ifu_rdata, ifu_rvalid, ifu_rlast,
    input  ready_o, valid_o, inst_o, pc_o,
    input  ifu_araddr_o, ifu_arlen_o, ifu_arvalid_o,
    input  perf_hit_o, perf_miss_o
  );
endinterface

// File: rtl/ysyx_ifu_l1i_array.sv
// ysyx L1I storage: per-way data, tag and valid arrays.
// Combinational set read, one-word write, global valid clear.
module ysyx_l1i_array #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 22,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int OFF_W      = 2,
  parameter int IDX_W      = 4,
  parameter int WAY_W      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IDX_W-1:0]            rd_idx,
  input  logic [OFF_W-1:0]            rd_off,
  output logic [WAYS-1:0]             rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]  rd_tag,
  output logic [WAYS-1:0][DATA_W-1:0] rd_word,
  input  logic                        wr_en,
  input  logic [WAY_W-1:0]            wr_way,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [OFF_W-1:0]            wr_off,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        tag_we,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic                        tag_valid,
  input  logic                        clr_all
);
  logic [DATA_W-1:0] data_q [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [SETS-1:0]   vld_q  [WAYS];

  // read every way of the addressed set
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_valid[w] = vld_q[w][rd_idx];
      rd_tag[w]   = tag_q[w][rd_idx];
      rd_word[w]  = data_q[w][rd_idx][rd_off];
    end
  end

  // refill beat and tag writes
  always_ff @(posedge clk) begin
    if (wr_en)
      data_q[wr_way][wr_idx][wr_off] <= wr_data;
    if (tag_we)
      tag_q[wr_way][wr_idx] <= wr_tag;
  end

  // valid bits: clear wins over line install
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      for (int w = 0; w < WAYS; w++)
        vld_q[w] <= '0;
    end else if (tag_we) begin
      vld_q[wr_way][wr_idx] <= tag_valid;
    end
  end
endmodule

// File: rtl/ysyx_ifu_l1i.sv
// ysyx instruction fetch unit with set-associative L1I.
// Hit in one cycle; miss refills a whole line by burst.
module ysyx_ifu_l1i
  import ysyx_ifu_l1i_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2
) (
  input logic          clk,
  input logic          rst,
  ysyx_ifu_l1i_if.master io
);
  localparam int OFF_W = clog2_min1(LINE_WORDS);
  localparam int IDX_W = clog2_min1(SETS);
  localparam int WAY_W = clog2_min1(WAYS);
  localparam int LSB   = OFF_W + 2;
  localparam int TAG_W = ADDR_W - IDX_W - LSB;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   inst_q;
  logic [OFF_W-1:0]    beat_q;
  logic                flush_q;
  logic [WAY_W-1:0]    vict_q;
  logic [WAY_W-1:0]    rr_q [SETS];

  logic [OFF_W-1:0]    off;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [WAYS-1:0]             rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][DATA_W-1:0] rd_word;
  logic                hit;
  logic [DATA_W-1:0]   hit_word;
  logic [WAY_W-1:0]    victim;
  logic                wr_en;
  logic                fill_done;
  logic                line_ok;

  assign off = pc_q[LSB-1:2];
  assign idx = pc_q[LSB+IDX_W-1:LSB];
  assign tag = pc_q[ADDR_W-1:LSB+IDX_W];

  ysyx_l1i_array #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .LINE_WORDS(LINE_WORDS),
    .SETS(SETS), .WAYS(WAYS), .OFF_W(OFF_W),
    .IDX_W(IDX_W), .WAY_W(WAY_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_off   (off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .wr_en    (wr_en),
    .wr_way   (vict_q),
    .wr_idx   (idx),
    .wr_off   (beat_q),
    .wr_data  (io.ifu_rdata),
    .tag_we   (fill_done),
    .wr_tag   (tag),
    .tag_valid(line_ok),
    .clr_all  (io.fence_i)
  );

  // tag compare, hit word select and victim choice
  always_comb begin
    logic found;
    logic [WAYS-1:0] vmask;
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && rd_tag[w] == tag) begin
        hit      = 1'b1;
        hit_word = hit_word | rd_word[w];
      end
    end
    hit   = hit && !io.fence_i;
    vmask = io.fence_i ? '0 : rd_valid;
    victim = rr_q[idx];
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !vmask[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  assign wr_en     = (state_q == S_R) && io.ifu_rvalid;
  assign fill_done = wr_en &&
    (io.ifu_rlast || beat_q == OFF_W'(LINE_WORDS - 1));
  assign line_ok   = (beat_q == OFF_W'(LINE_WORDS - 1)) &&
    !flush_q && !io.fence_i;

  // next-state and handshake outputs
  always_comb begin
    state_d          = state_q;
    io.ready_o       = 1'b0;
    io.valid_o       = 1'b0;
    io.inst_o        = inst_q;
    io.pc_o          = pc_q;
    io.ifu_araddr_o  = {pc_q[ADDR_W-1:LSB], LSB'(0)};
    io.ifu_arlen_o   = 8'(LINE_WORDS - 1);
    io.ifu_arvalid_o = 1'b0;
    io.perf_hit_o    = 1'b0;
    io.perf_miss_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        io.ready_o = 1'b1;
        if (io.prev_valid)
          state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          io.valid_o    = 1'b1;
          io.inst_o     = hit_word;
          io.perf_hit_o = 1'b1;
          state_d = io.next_ready ? S_IDLE : S_HOLD;
        end else begin
          io.perf_miss_o = 1'b1;
          state_d = S_AR;
        end
      end
      S_AR: begin
        io.ifu_arvalid_o = 1'b1;
        if (io.ifu_arready)
          state_d = S_R;
      end
      S_R: begin
        if (fill_done)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        io.valid_o = 1'b1;
        if (io.next_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, pc/inst latches, beat counter, flush pending
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      beat_q  <= '0;
      flush_q <= 1'b0;
      vict_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && io.prev_valid)
        pc_q <= io.pc;
      if (state_q == S_LOOKUP) begin
        if (hit)
          inst_q <= hit_word;
        else
          vict_q <= victim;
      end
      if (state_q == S_AR)
        beat_q <= '0;
      if (wr_en) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == off)
          inst_q <= io.ifu_rdata;
      end
      if (fill_done)
        flush_q <= 1'b0;
      else if (io.fence_i && (state_q == S_AR || state_q == S_R))
        flush_q <= 1'b1;
    end
  end

  // per-set round-robin replacement pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        rr_q[s] <= '0;
    end else if (fill_done) begin
      rr_q[idx] <= (WAYS == 1) ? '0 : rr_q[idx] + 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_ifu_l1i.sv
// ysyx IFU L1I bench: directed scenarios plus random fetches
// against a line-level cache reference model.
module tb_ysyx_ifu_l1i;
  localparam int LW   = 4;
  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  bit          mv   [SETS][WAYS];
  logic [31:0] mtag [SETS][WAYS];
  int          mrr  [SETS];

  ysyx_ifu_l1i_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_ifu_l1i #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW),
    .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5a5a_1234 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / (LW * 4)) % SETS);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % (LW * 4));
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int s = 0; s < SETS; s++) mrr[s] = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mtag[s][w] == line_of(a)) return 1;
    return 0;
  endfunction

  function automatic int model_victim(input logic [31:0] a);
    int s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (!mv[s][w]) return w;
    return mrr[s];
  endfunction

  task automatic model_fill(input logic [31:0] a, input int v, input bit ok);
    int s = set_of(a);
    mtag[s][v] = line_of(a);
    mv[s][v]   = ok;
    mrr[s]     = (mrr[s] + 1) % WAYS;
  endtask

  // fmode: 0 none, 1 fence with acceptance, 2 fence in lookup,
  // 3 fence during beat fb. nb = beats sent (rlast on the last).
  task automatic fetch(input logic [31:0] a, input int hold, input int arw,
                       input int fmode, input int fb, input int nb);
    bit exp_hit, fenced;
    int np, vic;
    logic [31:0] line = line_of(a);
    logic [31:0] ei = memf(a);
    fenced = 0;
    @(negedge clk);
    chk("rdy_idle", 32'(bus.ready_o), 1);
    bus.prev_valid = 1'b1;
    bus.pc         = a;
    bus.next_ready = (hold == 0);
    bus.fence_i    = (fmode == 1);
    if (fmode == 1) model_clear();
    @(negedge clk);
    bus.prev_valid = 1'b0;
    bus.fence_i    = 1'b0;
    bus.pc         = $urandom;
    if (fmode == 2) begin
      bus.fence_i = 1'b1;
      #1;
      model_clear();
    end
    exp_hit = model_hit(a);
    vic = model_victim(a);
    np = int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
    chk("perf_hit", 32'(bus.perf_hit_o), 32'(exp_hit));
    chk("perf_miss", 32'(bus.perf_miss_o), 32'(!exp_hit));
    chk("valid_lk", 32'(bus.valid_o), 32'(exp_hit));
    chk("rdy_busy", 32'(bus.ready_o), 0);
    chk("arv_lk", 32'(bus.ifu_arvalid_o), 0);
    if (exp_hit) begin
      chk("inst_hit", bus.inst_o, ei);
      chk("pc_hit", bus.pc_o, a);
    end else begin
      @(negedge clk);
      bus.fence_i = 1'b0;
      np += int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
      for (int i = 0; i < arw; i++) begin
        chk("arv_wait", 32'(bus.ifu_arvalid_o), 1);
        @(negedge clk);
        np += int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
      end
      chk("arvalid", 32'(bus.ifu_arvalid_o), 1);
      chk("araddr", bus.ifu_araddr_o, line);
      chk("arlen", 32'(bus.ifu_arlen_o), LW - 1);
      bus.ifu_arready = 1'b1;
      @(negedge clk);
      bus.ifu_arready = 1'b0;
      chk("arv_drop", 32'(bus.ifu_arvalid_o), 0);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          np += int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
        end
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata  = memf(line + 32'(4 * b));
        bus.ifu_rlast  = (b == nb - 1);
        bus.fence_i    = (fmode == 3 && b == fb);
        if (fmode == 3 && b == fb) begin
          fenced = 1;
          model_clear();
        end
        @(negedge clk);
        np += int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
        bus.ifu_rvalid = 1'b0;
        bus.ifu_rlast  = 1'b0;
        bus.fence_i    = 1'b0;
        if (b < nb - 1) chk("valid_r", 32'(bus.valid_o), 0);
      end
      model_fill(a, vic, !fenced && nb == LW);
      chk("valid_hold", 32'(bus.valid_o), 1);
      chk("inst_miss", bus.inst_o, ei);
      chk("pc_miss", bus.pc_o, a);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      np += int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
      chk("valid_bp", 32'(bus.valid_o), 1);
      chk("inst_bp", bus.inst_o, ei);
      chk("rdy_bp", 32'(bus.ready_o), 0);
    end
    bus.next_ready = 1'b1;
    @(negedge clk);
    np += int'(bus.perf_hit_o) + int'(bus.perf_miss_o);
    bus.next_ready = 1'b0;
    chk("rdy_done", 32'(bus.ready_o), 1);
    chk("valid_done", 32'(bus.valid_o), 0);
    chk("pulses", 32'(np), 1);
  endtask

  task automatic reset_in_r(input logic [31:0] a);
    @(negedge clk);
    bus.prev_valid = 1'b1;
    bus.pc         = a;
    @(negedge clk);
    bus.prev_valid = 1'b0;
    chk("rr_miss", 32'(bus.perf_miss_o), 32'(!model_hit(a)));
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk("rr_arv", 32'(bus.ifu_arvalid_o), 1);
      @(negedge clk);
    end
    bus.ifu_arready = 1'b1;
    @(negedge clk);
    bus.ifu_arready = 1'b0;
    bus.ifu_rvalid  = 1'b1;
    bus.ifu_rdata   = memf(line_of(a));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rr_arv_drop", 32'(bus.ifu_arvalid_o), 0);
    chk("rr_ready", 32'(bus.ready_o), 1);
    chk("rr_valid", 32'(bus.valid_o), 0);
    bus.ifu_rlast = 1'b1;
    repeat (2) @(negedge clk);
    chk("rr_stale_v", 32'(bus.valid_o), 0);
    chk("rr_stale_r", 32'(bus.ready_o), 1);
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rlast  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int fm, nb;
    bus.prev_valid  = 1'b0;
    bus.pc          = '0;
    bus.next_ready  = 1'b0;
    bus.fence_i     = 1'b0;
    bus.ifu_arready = 1'b0;
    bus.ifu_rdata   = '0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rlast   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 1);
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_arv", 32'(bus.ifu_arvalid_o), 0);
    chk("rst_hit", 32'(bus.perf_hit_o), 0);
    chk("rst_miss", 32'(bus.perf_miss_o), 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    rst = 1'b0;

    fetch(32'h8000_0008, 0, 2, 0, 0, LW);
    fetch(32'h8000_000C, 0, 0, 0, 0, LW);
    fetch(32'h8000_0100, 0, 1, 0, 0, LW);
    fetch(32'h8000_0200, 0, 0, 0, 0, LW);
    fetch(32'h8000_0000, 0, 0, 0, 0, LW);
    chk("evict_hit", 32'(model_hit(32'h8000_0200)), 1);
    fetch(32'h8000_0200, 0, 0, 0, 0, LW);
    fetch(32'h8000_0204, 5, 0, 0, 0, LW);
    fetch(32'h8000_0048, 0, 0, 3, 2, LW);
    fetch(32'h8000_0048, 0, 0, 0, 0, LW);
    fetch(32'h8000_0080, 0, 1, 0, 0, 2);
    fetch(32'h8000_0084, 0, 0, 0, 0, LW);
    fetch(32'h8000_0048, 0, 0, 1, 0, LW);
    fetch(32'h8000_0048, 2, 0, 2, 0, LW);
    reset_in_r(32'h8000_0084);
    fetch(32'h8000_0084, 0, 0, 0, 0, LW);

    for (int n = 0; n < 120; n++) begin
      a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 8)
        | (32'($urandom_range(0, 1)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      case ($urandom_range(0, 11))
        0: fm = 1;
        1: fm = 2;
        2: fm = 3;
        default: fm = 0;
      endcase
      nb = LW;
      if ($urandom_range(0, 7) == 0) nb = int'(a[3:2]) + 1;
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), fm,
            $urandom_range(0, LW - 1), nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
